// File: rtl/ControlSignals.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Package     : ControlSignals
//  Description : Shared control encodings: ALU opcodes and multiply-sequencer
//                FSM states.
//  Revision    : 1.0
// ============================================================================
package ControlSignals;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_SLL  = 4'd5,
      OP_SRL  = 4'd6,
      OP_SRA  = 4'd7,
      OP_SLT  = 4'd8,
      OP_SLTU = 4'd9
   } aluOperation_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } mulSeqState_t;

endpackage : ControlSignals
`default_nettype wire

// File: rtl/mul_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mul_sequencer
//  Description : Shift-and-add unsigned multiplier that borrows the shared
//                external ALU for its additions; returns the low half of the
//                product. Define MUL_SEQ_EARLY_EXIT_EN to finish as soon as
//                the remaining multiplier bits are all zero.
//  Revision    : 1.0
// ============================================================================
module mul_sequencer
   import ControlSignals::*;
#(
   parameter  int REG_DATA_WIDTH_POW = 6,
   localparam int REG_DATA_WIDTH     = 1 << REG_DATA_WIDTH_POW
) (
   input  logic                      clk_in,
   input  logic                      rstN_in,
   input  logic                      reqValid_in,
   output logic                      reqReady_out,
   input  logic [REG_DATA_WIDTH-1:0] multiplicand_in,
   input  logic [REG_DATA_WIDTH-1:0] multiplier_in,
   input  logic                      flush_in,
   output logic                      resultValid_out,
   input  logic                      resultReady_in,
   output logic [REG_DATA_WIDTH-1:0] product_out,
   output logic [REG_DATA_WIDTH-1:0] aluOperand1_out,
   output logic [REG_DATA_WIDTH-1:0] aluOperand2_out,
   output aluOperation_t             aluOpcode_out,
   input  logic [REG_DATA_WIDTH-1:0] aluResult_in
);

   // Count saturates at all-ones, which is exactly REG_DATA_WIDTH-1.
   localparam logic [REG_DATA_WIDTH_POW-1:0] c_LAST_COUNT = '1;

   mulSeqState_t                  r_state;
   mulSeqState_t                  w_nextState;
   logic [REG_DATA_WIDTH-1:0]     r_acc;
   logic [REG_DATA_WIDTH-1:0]     r_mcand;
   logic [REG_DATA_WIDTH-1:0]     r_mplier;
   logic [REG_DATA_WIDTH_POW-1:0] r_count;
   logic [REG_DATA_WIDTH-1:0]     w_mplierShift;
   logic                          w_accept;
   logic                          w_lastStep;
   logic                          w_skipCalc;

   assign w_mplierShift = r_mplier >> 1;

`ifdef MUL_SEQ_EARLY_EXIT_EN
   assign w_lastStep = (r_count == c_LAST_COUNT) || (w_mplierShift == '0);
   assign w_skipCalc = (multiplier_in == '0);
`else
   assign w_lastStep = (r_count == c_LAST_COUNT);
   assign w_skipCalc = 1'b0;
`endif

   always_ff @(posedge clk_in or negedge rstN_in) begin
      if (!rstN_in) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_accept    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (reqValid_in) begin
               w_accept    = 1'b1;
               w_nextState = w_skipCalc ? DONE : CALC;
            end
         end
         CALC: begin
            if (w_lastStep) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            if (resultReady_in) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
      // Flush beats everything, including a pending accept.
      if (flush_in) begin
         w_nextState = IDLE;
         w_accept    = 1'b0;
      end
   end

   always_ff @(posedge clk_in or negedge rstN_in) begin
      if (!rstN_in) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_count  <= '0;
      end else if (w_accept) begin
         r_acc    <= '0;
         r_mcand  <= multiplicand_in;
         r_mplier <= multiplier_in;
         r_count  <= '0;
      end else if ((r_state == CALC) && !flush_in) begin
         if (r_mplier[0]) begin
            r_acc <= aluResult_in;
         end
         r_mcand  <= r_mcand << 1;
         r_mplier <= w_mplierShift;
         r_count  <= r_count + 1'b1;
      end
   end

   // ALU request is static; the parent only consumes it while in CALC.
   assign aluOperand1_out = r_acc;
   assign aluOperand2_out = r_mcand;
   assign aluOpcode_out   = OP_ADD;

   assign reqReady_out    = (r_state == IDLE);
   assign resultValid_out = (r_state == DONE);
   assign product_out     = r_acc;

endmodule : mul_sequencer
`default_nettype wire

// File: tb/tb_mul_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mul_sequencer
//  Description : Directed scoreboard bench for mul_sequencer with a behavioural
//                shared ALU. Honours MUL_SEQ_EARLY_EXIT_EN for latency.
//  Revision    : 1.0
// ============================================================================
module tb_mul_sequencer;
   import ControlSignals::*;

   localparam int W = 64;

   logic          clk         = 1'b0;
   logic          rstN        = 1'b0;
   logic          reqValid    = 1'b0;
   logic          flush       = 1'b0;
   logic          resultReady = 1'b0;
   logic [W-1:0]  mcand       = '0;
   logic [W-1:0]  mplier      = '0;
   logic          reqReady;
   logic          resultValid;
   logic [W-1:0]  product;
   logic [W-1:0]  op1;
   logic [W-1:0]  op2;
   logic [W-1:0]  aluRes;
   aluOperation_t opc;

   int            nAsserts = 0;
   int            nFail    = 0;
   logic [W-1:0]  expQ[$];
   logic [W-1:0]  expProd;
   logic [W-1:0]  ra;
   logic [W-1:0]  rb;
   int            seen;

   mul_sequencer #(.REG_DATA_WIDTH_POW(6)) dut (
      .clk_in          (clk),
      .rstN_in         (rstN),
      .reqValid_in     (reqValid),
      .reqReady_out    (reqReady),
      .multiplicand_in (mcand),
      .multiplier_in   (mplier),
      .flush_in        (flush),
      .resultValid_out (resultValid),
      .resultReady_in  (resultReady),
      .product_out     (product),
      .aluOperand1_out (op1),
      .aluOperand2_out (op2),
      .aluOpcode_out   (opc),
      .aluResult_in    (aluRes)
   );

   always #5 clk = ~clk;

   assign aluRes = (opc == OP_ADD) ? op1 + op2 : 'x;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int expLat(input logic [W-1:0] b);
`ifdef MUL_SEQ_EARLY_EXIT_EN
      int l = 1;
      for (int i = 0; i < W; i++) if (b[i]) l = i + 2;
      return l;
`else
      return W + 1;
`endif
   endfunction

   // Returns #1 after the accept edge.
   task automatic request(input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      check("reqReady_idle", {63'd0, reqReady}, 64'd1);
      reqValid = 1'b1;
      mcand    = a;
      mplier   = b;
      @(posedge clk);
      expQ.push_back(a * b);
      #1 reqValid = 1'b0;
   endtask

   // Latency counts the accept edge as cycle 1.
   task automatic waitValid(input string tag, input int expL);
      int lat = 1;
      int bad = 0;
      while (resultValid !== 1'b1 && lat < 200) begin
         if (opc !== OP_ADD) bad++;
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'(expL));
      check({tag, "_opcode"}, 64'(bad), 64'd0);
   endtask

   task automatic consume(input string tag, input int stall);
      for (int i = 0; i < stall; i++) begin
         @(posedge clk);
         #1;
         check({tag, "_stall_product"}, product, expQ[0]);
         check({tag, "_stall_reqReady"}, {63'd0, reqReady}, 64'd0);
         check({tag, "_stall_valid"}, {63'd0, resultValid}, 64'd1);
      end
      @(negedge clk);
      resultReady = 1'b1;
      expProd = expQ.pop_front();
      check({tag, "_product"}, product, expProd);
      @(posedge clk);
      #1 resultReady = 1'b0;
      check({tag, "_valid_after"}, {63'd0, resultValid}, 64'd0);
      check({tag, "_idle_after"}, {63'd0, reqReady}, 64'd1);
   endtask

   task automatic checkResetOutputs(input string tag);
      check({tag, "_reqReady"}, {63'd0, reqReady}, 64'd1);
      check({tag, "_valid"}, {63'd0, resultValid}, 64'd0);
      check({tag, "_product"}, product, 64'd0);
      check({tag, "_op1"}, op1, 64'd0);
      check({tag, "_op2"}, op2, 64'd0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      checkResetOutputs("reset");
      rstN = 1'b1;

      request(64'd3, 64'd5);
      waitValid("3x5", expLat(64'd5));
      consume("3x5", 0);

      request(64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
      waitValid("wrap", expLat(64'd2));
      consume("wrap", 10);

      request(64'd123, 64'd0);
      waitValid("zero", expLat(64'd0));
      consume("zero", 0);

      for (int k = 0; k < 3; k++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         request(ra, rb);
         waitValid("rand", expLat(rb));
         consume("rand", k);
      end

      // Flush while idle must not disturb anything.
      @(negedge clk) flush = 1'b1;
      @(negedge clk) flush = 1'b0;
      check("idle_flush_reqReady", {63'd0, reqReady}, 64'd1);
      check("idle_flush_valid", {63'd0, resultValid}, 64'd0);

      // Flush mid-calculation, with a competing request held high.
      request(64'h1234, 64'h8000_0000_0000_0001);
      reqValid = 1'b1;
      mcand    = 64'd9;
      mplier   = 64'd9;
      seen     = 0;
      repeat (19) begin
         @(posedge clk);
         #1;
         if (resultValid === 1'b1 || reqReady === 1'b1) seen++;
      end
      check("calc_busy", 64'(seen), 64'd0);
      @(negedge clk);
      reqValid = 1'b0;
      flush    = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      check("flush_idle", {63'd0, reqReady}, 64'd1);
      void'(expQ.pop_back());
      seen = 0;
      repeat (5) begin
         @(posedge clk);
         #1;
         if (resultValid === 1'b1) seen++;
      end
      check("flush_no_result", 64'(seen), 64'd0);
      request(64'd7, 64'd6);
      waitValid("7x6", expLat(64'd6));
      consume("7x6", 0);

      // Asynchronous reset mid-calculation.
      request(64'd5, 64'h8000_0000_0000_0003);
      repeat (29) @(posedge clk);
      #1;
      check("pre_reset_valid", {63'd0, resultValid}, 64'd0);
      #2 rstN = 1'b0;
      #1;
      checkResetOutputs("async_reset");
      void'(expQ.pop_back());
      @(negedge clk);
      @(negedge clk) rstN = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_reqReady", {63'd0, reqReady}, 64'd1);
      check("post_reset_valid", {63'd0, resultValid}, 64'd0);
      request(64'd9, 64'd9);
      waitValid("9x9", expLat(64'd9));
      consume("9x9", 0);

      check("queue_empty", 64'(expQ.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
      $finish;
   end

endmodule : tb_mul_sequencer
`default_nettype wire

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 SHALL have parameter REG_DATA_WIDTH_POW, default 6, log2 of the operand width.
REQ-002 SHALL have localparam REG_DATA_WIDTH, value 1 << REG_DATA_WIDTH_POW, operand/result width.
REQ-003 SHALL have port clk_in, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstN_in, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports reqValid_in (input, 1) and reqReady_out (output, 1), the request handshake.
REQ-006 SHALL have ports multiplicand_in and multiplier_in, input, REG_DATA_WIDTH each, unsigned operands.
REQ-007 SHALL have port flush_in, input, 1, synchronous abort.
REQ-008 SHALL have ports resultValid_out (output, 1) and resultReady_in (input, 1), the result handshake.
REQ-009 SHALL have port product_out, output, REG_DATA_WIDTH, low half of the product.
REQ-010 SHALL have ports aluOperand1_out and aluOperand2_out, output, REG_DATA_WIDTH each, driven to the external shared ALU.
REQ-011 SHALL have port aluOpcode_out, output, aluOperation_t, driven to the ALU.
REQ-012 SHALL have port aluResult_in, input, REG_DATA_WIDTH, the combinational ALU result in the same cycle.

Function
REQ-013 SHALL implement states IDLE, CALC and DONE.
REQ-014 SHALL assert reqReady_out only in IDLE; a request is accepted on an edge where reqValid_in and reqReady_out are both 1.
REQ-015 On accept SHALL load acc=0, mcand=multiplicand_in, mplier=multiplier_in, count=0, then go to CALC.
REQ-016 In every CALC cycle SHALL drive aluOperand1_out=acc, aluOperand2_out=mcand, aluOpcode_out=OP_ADD.
REQ-017 In each CALC edge SHALL, if mplier[0]=1, update acc<=aluResult_in, otherwise hold acc; and SHALL update mcand<<=1, mplier>>=1, count+=1.
REQ-018 Arithmetic SHALL be modulo 2^REG_DATA_WIDTH; bits shifted out of mcand and the ALU carry SHALL be discarded.
REQ-019 CALC SHALL transition to DONE on the edge processing count=REG_DATA_WIDTH-1 (subject to REQ-028).
REQ-020 Outside CALC, the ALU outputs SHALL still reflect acc/mcand with OP_ADD, and these values SHALL be ignored.
REQ-021 In DONE SHALL assert resultValid_out with product_out=acc, held stable until resultReady_in=1.
REQ-022 DONE with resultReady_in=1 SHALL go to IDLE on that edge; no back-to-back accept in the same cycle.
REQ-023 Baseline latency: resultValid_out SHALL be 1 exactly REG_DATA_WIDTH+1 cycles after the accept edge.
REQ-024 flush_in=1 SHALL force IDLE on the next edge from any state and discard the result, with priority over all other transitions; flush in IDLE SHALL be a no-op.
REQ-025 reqValid_in while not in IDLE SHALL be ignored (reqReady_out=0).

Reset
REQ-026 While rstN_in=0 SHALL be in IDLE with acc, mcand, mplier and count all 0, reqReady_out=1, resultValid_out=0 and product_out=0.
REQ-027 Reset mid-operation SHALL abandon the operation; no result is produced for it.

Configuration
REQ-028 With MUL_SEQ_EARLY_EXIT_EN defined, SHALL go to DONE on the CALC edge whose post-shift mplier is 0.
REQ-029 With MUL_SEQ_EARLY_EXIT_EN defined, an accept with multiplier_in=0 SHALL go directly to DONE with acc=0.
REQ-030 Without MUL_SEQ_EARLY_EXIT_EN, latency SHALL always be per REQ-023.

Structure
REQ-031 aluOperation_t SHALL be imported from package ControlSignals.
REQ-032 A new mulSeqState_t enum (IDLE/CALC/DONE) SHALL be added to package ControlSignals.
REQ-033 The block SHALL be flat with no sub-module; the ALU SHALL be instantiated by the parent and connected via the alu* ports.

Verification
REQ-034 3 x 5, no macro -> resultValid_out 65 cycles after accept, product_out=15; OP_ADD on every CALC cycle.
REQ-035 3 x 5 with MUL_SEQ_EARLY_EXIT_EN -> resultValid_out 4 cycles after accept, product_out=15.
REQ-036 0xFFFFFFFFFFFFFFFF x 2 -> product_out=0xFFFFFFFFFFFFFFFE (wrap); multiplier 0 with macro -> valid 1 cycle after accept, product 0.
REQ-037 Result backpressure: resultReady_in=0 for 10 cycles -> product_out stable, reqReady_out=0; on resultReady_in=1 -> IDLE next cycle.
REQ-038 flush_in pulse at CALC cycle 20 -> IDLE next edge; resultValid_out never asserted; new request 7 x 6 -> product_out=42.
REQ-039 rstN_in low at CALC cycle 30 -> all outputs at reset values immediately (asynchronous); after release, reqReady_out=1.
